// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART transmitter slice.
//               tx_state_e  - transmitter frame state
//               parity_e    - parity mode encoding as seen on cfg_parity
//               c_PAR_*     - parity encoding constants
//               parity_enabled() - true when the mode inserts a parity bit
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } tx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_e;

    localparam logic [1:0] c_PAR_NONE = 2'b00;
    localparam logic [1:0] c_PAR_EVEN = 2'b01;
    localparam logic [1:0] c_PAR_ODD  = 2'b10;

    // Encoding 2'b11 is treated as "no parity".
    function automatic logic parity_enabled(input logic [1:0] cfg);
        return (cfg == c_PAR_EVEN) || (cfg == c_PAR_ODD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Transmit word queue with head-of-queue read-through.
//               Used by uart_tx_param only when UART_TX_FIFO_EN is defined.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               push, push_data - write one word (ignored when full)
//               pop             - drop the head word (ignored when empty)
//               head_data       - oldest queued word
//               level           - number of queued words
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head_data,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_LVL_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_LVL_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign w_push    = push && (r_count < c_LVL_W'(DEPTH));
    assign w_pop     = pop && (r_count != '0);
    assign head_data = r_mem[r_rd_ptr];
    assign level     = r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_param
// Description : Parameterised UART transmitter. Frame = start, DATA_W data
//               bits LSB first, optional parity, one or two stop bits.
//               Frame configuration is latched when a word is popped.
// Build macro : UART_TX_FIFO_EN - FIFO_DEPTH-entry queue (uart_tx_fifo);
//               undefined      - single holding register.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               baud_tick           - one-clk pulse per bit period
//               tx_valid/tx_ready   - word handshake, tx_data the word
//               cfg_parity          - 00 none, 01 even, 10 odd, 11 none
//               cfg_stop2           - two stop bits when high
//               tx_out              - registered serial line, idle high
//               tx_busy             - frame in progress
//               tx_done             - one-clk pulse at frame end
//               level               - words queued, not yet started
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            baud_tick,
    input  logic                            tx_valid,
    input  logic [DATA_W-1:0]               tx_data,
    output logic                            tx_ready,
    input  logic [1:0]                      cfg_parity,
    input  logic                            cfg_stop2,
    output logic                            tx_out,
    output logic                            tx_busy,
    output logic                            tx_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] level
);

    localparam int         c_LVL_W    = $clog2(FIFO_DEPTH+1);
    localparam logic [3:0] c_LAST_BIT = 4'(DATA_W-1);

    tx_state_e          r_state;
    logic [3:0]         r_bit_cnt;
    logic [DATA_W-1:0]  r_shift;
    logic               r_par_en;
    logic               r_par_bit;
    logic               r_stop2;
    logic               r_tx;
    logic               r_done;

    logic               w_push;
    logic               w_pop;
    logic               w_frame_end;
    logic [DATA_W-1:0]  w_head;
    logic [c_LVL_W-1:0] w_level;

    assign w_push = tx_valid && tx_ready;

`ifdef UART_TX_FIFO_EN
    uart_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (tx_data),
        .pop       (w_pop),
        .head_data (w_head),
        .level     (w_level)
    );

    assign tx_ready = (w_level < c_LVL_W'(FIFO_DEPTH));
`else
    logic              r_hold_valid;
    logic [DATA_W-1:0] r_hold;

    // Push requires an empty holder and pop a full one, so they never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_valid <= 1'b0;
            r_hold       <= '0;
        end else if (w_push) begin
            r_hold       <= tx_data;
            r_hold_valid <= 1'b1;
        end else if (w_pop) begin
            r_hold_valid <= 1'b0;
        end
    end

    assign w_head   = r_hold;
    assign w_level  = c_LVL_W'(r_hold_valid);
    assign tx_ready = !r_hold_valid;
`endif

    // Last tick of the final stop bit closes the frame.
    assign w_frame_end = baud_tick &&
                         (((r_state == ST_STOP1) && !r_stop2) || (r_state == ST_STOP2));

    // A new frame starts from IDLE or directly on the closing tick of the
    // previous one, so back-to-back words carry no idle bit.
    assign w_pop = baud_tick && (w_level != '0) &&
                   ((r_state == ST_IDLE) || w_frame_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_stop2   <= 1'b0;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_frame_end;
            if (w_pop) begin
                r_shift   <= w_head;
                r_par_en  <= parity_enabled(cfg_parity);
                r_par_bit <= (^w_head) ^ (cfg_parity == c_PAR_ODD);
                r_stop2   <= cfg_stop2;
                r_state   <= ST_START;
                r_tx      <= 1'b0;
            end else if (baud_tick) begin
                case (r_state)
                    ST_START: begin
                        r_state   <= ST_DATA;
                        r_bit_cnt <= '0;
                        r_tx      <= r_shift[0];
                    end
                    ST_DATA: begin
                        if (r_bit_cnt == c_LAST_BIT) begin
                            r_bit_cnt <= '0;
                            if (r_par_en) begin
                                r_state <= ST_PARITY;
                                r_tx    <= r_par_bit;
                            end else begin
                                r_state <= ST_STOP1;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                        end
                    end
                    ST_PARITY: begin
                        r_state <= ST_STOP1;
                        r_tx    <= 1'b1;
                    end
                    ST_STOP1: begin
                        r_state <= r_stop2 ? ST_STOP2 : ST_IDLE;
                        r_tx    <= 1'b1;
                    end
                    ST_STOP2: begin
                        r_state <= ST_IDLE;
                        r_tx    <= 1'b1;
                    end
                    ST_IDLE: begin
                        r_tx <= 1'b1;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign tx_out  = r_tx;
    assign tx_done = r_done;
    assign tx_busy = (r_state != ST_IDLE);
    assign level   = w_level;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_param
// Description : Self-checking bench for uart_tx_param (DATA_W=8, depth 4).
//               Accepted words are turned into expected line frames and
//               queued; a line monitor rebuilds each frame from tx_out on
//               baud ticks and compares it when tx_done fires.
//               Works with UART_TX_FIFO_EN defined or undefined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_param;

    localparam int c_DATA_W = 8;
    localparam int c_DEPTH  = 4;
`ifdef UART_TX_FIFO_EN
    localparam int c_CAP = c_DEPTH;
`else
    localparam int c_CAP = 1;
`endif

    typedef struct {
        logic [15:0] bits;
        int          len;
    } frame_t;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic                          baud_tick = 1'b0;
    logic                          tx_valid = 1'b0;
    logic [c_DATA_W-1:0]           tx_data = '0;
    logic                          tx_ready;
    logic [1:0]                    cfg_parity = 2'b00;
    logic                          cfg_stop2 = 1'b0;
    logic                          tx_out;
    logic                          tx_busy;
    logic                          tx_done;
    logic [$clog2(c_DEPTH+1)-1:0]  level;

    int n_tests = 0;
    int n_fail  = 0;

    frame_t      exp_q[$];
    logic        done_busy_q[$];
    int          len_q[$];
    int          done_count = 0;
    logic [15:0] col_bits = '0;
    int          col_len = 0;
    logic [15:0] last_bits = '0;
    int          last_len = 0;
    logic        prev_tick = 1'b0;
    logic        prev_rst = 1'b1;

    uart_tx_param #(
        .DATA_W     (c_DATA_W),
        .FIFO_DEPTH (c_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_tick  (baud_tick),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .tx_out     (tx_out),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .level      (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Line image of one frame: index 0 is the start bit.
    function automatic frame_t make_frame(input logic [7:0] d, input logic [1:0] par,
                                          input logic s2);
        frame_t f;
        f.bits = '0;
        f.bits[0] = 1'b0;
        f.len = 1;
        for (int i = 0; i < 8; i++) begin
            f.bits[f.len] = d[i];
            f.len++;
        end
        if (par == 2'b01) begin
            f.bits[f.len] = ^d;
            f.len++;
        end else if (par == 2'b10) begin
            f.bits[f.len] = ~(^d);
            f.len++;
        end
        f.bits[f.len] = 1'b1;
        f.len++;
        if (s2) begin
            f.bits[f.len] = 1'b1;
            f.len++;
        end
        return f;
    endfunction

    always @(posedge clk) begin
        prev_tick <= baud_tick;
        prev_rst  <= rst;
    end

    // Inputs only change 1 time unit after posedge, so at negedge they show
    // exactly what the next posedge will see.
    always @(negedge clk) begin
        frame_t e;
        if (prev_rst) begin
            col_bits = '0;
            col_len  = 0;
            exp_q.delete();
        end else if (prev_tick) begin
            if (tx_done) begin
                done_count++;
                done_busy_q.push_back(tx_busy);
                len_q.push_back(col_len);
                last_bits = col_bits;
                last_len  = col_len;
                if (exp_q.size() == 0) begin
                    check("exp_queue_nonempty", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_len", col_len, e.len);
                    check("frame_bits", {16'h0, col_bits}, {16'h0, e.bits});
                end
                col_bits = '0;
                col_len  = 0;
            end
            if (tx_busy && col_len < 16) begin
                col_bits[col_len] = tx_out;
                col_len++;
            end
        end else if (tx_done) begin
            check("done_off_tick", tx_done, 0);
        end
        if (!rst && tx_valid && tx_ready) begin
            exp_q.push_back(make_frame(tx_data, cfg_parity, cfg_stop2));
        end
    end

    // All tasks start and end 1 time unit after a posedge.
    task automatic pulse_ticks(input int n);
        repeat (n) begin
            baud_tick = 1'b1;
            @(posedge clk); #1;
            baud_tick = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] d);
        logic ok;
        ok = 1'b0;
        tx_data  = d;
        tx_valid = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            ok = tx_ready;
            @(posedge clk); #1;
        end
        tx_valid = 1'b0;
        check("push_accepted", ok, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        // ---------------- reset state ----------------
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_out", tx_out, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_level", level, 0);
        check("rst_ready", tx_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        // ---------------- 0xA5, even, one stop ----------------
        cfg_parity = 2'b01; cfg_stop2 = 1'b0;
        d0 = done_count;
        push(8'hA5);
        check("level_after_push", level, 1);
        pulse_ticks(12);
        check("a5_even_bits", {16'h0, last_bits}, 32'h0000_054A);
        check("a5_even_len", last_len, 11);
        check("a5_even_dones", done_count - d0, 1);
        check("a5_even_idle", tx_busy, 0);

        // ---------------- 0xA5, odd, two stops ----------------
        cfg_parity = 2'b10; cfg_stop2 = 1'b1;
        d0 = done_count;
        push(8'hA5);
        pulse_ticks(13);
        check("a5_odd_bits", {16'h0, last_bits}, 32'h0000_0F4A);
        check("a5_odd_len", last_len, 12);
        check("a5_odd_dones", done_count - d0, 1);
        check("a5_odd_line_idle", tx_out, 1);

        // ---------------- back-to-back 0x00, 0xFF ----------------
        cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        d0 = done_count;
        done_busy_q.delete();
        push(8'h00);
        pulse_ticks(1);
        push(8'hFF);
        pulse_ticks(21);
        check("b2b_dones", done_count - d0, 2);
        check("b2b_done_log", done_busy_q.size(), 2);
        if (done_busy_q.size() == 2) begin
            check("b2b_no_idle_bit", done_busy_q[0], 1);
            check("b2b_end_idle", done_busy_q[1], 0);
        end

        // ---------------- parity change mid-frame ----------------
        cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        len_q.delete();
        push(8'h3C);
        pulse_ticks(3);
        cfg_parity = 2'b10;
        push(8'h3C);
        pulse_ticks(20);
        check("cfgchg_frames", len_q.size(), 2);
        if (len_q.size() == 2) begin
            check("cfgchg_first_len", len_q[0], 10);
            check("cfgchg_second_len", len_q[1], 11);
        end

        // ---------------- queue capacity / held source ----------------
        cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        d0 = done_count;
        for (int i = 0; i < c_CAP; i++) push(8'h10 + 8'(i));
        check("cap_level_full", level, c_CAP);
        check("cap_ready_low", tx_ready, 0);
        tx_data  = 8'hEE;
        tx_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("cap_held_level", level, c_CAP);
        check("cap_held_ready", tx_ready, 0);
        baud_tick = 1'b1;
        @(posedge clk); #1;
        baud_tick = 1'b0;
        check("cap_ready_after_pop", tx_ready, 1);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        check("cap_level_refill", level, c_CAP);
        pulse_ticks((c_CAP + 1) * 10 + 2);
        check("cap_dones", done_count - d0, c_CAP + 1);
        check("cap_level_empty", level, 0);

        // ---------------- reset during DATA bit 3 ----------------
        cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        push(8'h5A);
        pulse_ticks(1);
        push(8'h11);
        pulse_ticks(4);
        check("abort_pre_busy", tx_busy, 1);
        check("abort_pre_bit3", tx_out, 1);
        check("abort_pre_level", level, 1);
        d0 = done_count;
        rst = 1'b1;
        baud_tick = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        baud_tick = 1'b0;
        check("abort_tx_out", tx_out, 1);
        check("abort_busy", tx_busy, 0);
        check("abort_level", level, 0);
        check("abort_done", tx_done, 0);
        check("abort_ready", tx_ready, 1);
        pulse_ticks(15);
        check("abort_no_done", done_count - d0, 0);
        check("abort_line_idle", tx_out, 1);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
